// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: accepts one request at a time, checks func3 and
// alignment, runs a handshaked word access with timeout, and returns extended load data.
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp_data;
    logic        r_err;
    logic [7:0]  r_cnt;

    logic        w_illegal;
    logic        w_accept;
    logic        w_ack_take;
    logic        w_timeout;
    logic        w_in_access;
    logic        w_in_resp;
    logic [3:0]  w_be;
    logic [31:0] w_store_data;
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;

    // Legality is judged on the live request so an illegal one never reaches memory.
    always_comb begin
        w_illegal = 1'b0;
        if (req_we) begin
            unique case (req_func3)
                F3_B:    w_illegal = 1'b0;
                F3_H:    w_illegal = req_addr[0];
                F3_W:    w_illegal = |req_addr[1:0];
                default: w_illegal = 1'b1;
            endcase
        end else begin
            unique case (req_func3)
                F3_B, F3_BU: w_illegal = 1'b0;
                F3_H, F3_HU: w_illegal = req_addr[0];
                F3_W:        w_illegal = |req_addr[1:0];
                default:     w_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: captured registers are reset too, so the decoded outputs start at a known 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rsp_data <= 32'h0;
            r_err      <= 1'b0;
            r_cnt      <= 8'h0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_func3    <= req_func3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rsp_data <= 32'h0;
            r_err      <= w_illegal;
            r_cnt      <= 8'h0;
        end else if (w_ack_take) begin
            r_rsp_data <= r_we ? 32'h0 : w_load_ext;
            r_err      <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_data <= 32'h0;
            r_err      <= 1'b1;
        end else if (r_state == S_ACCESS) begin
            r_cnt      <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_be = 4'b1111;
        unique case (r_func3[1:0])
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = 4'b0011 << r_addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_store_data = 32'h0;
        if (r_we) begin
            unique case (r_func3[1:0])
                2'b00:   w_store_data = {4{r_wdata[7:0]}};
                2'b01:   w_store_data = {2{r_wdata[15:0]}};
                default: w_store_data = r_wdata;
            endcase
        end
    end

    assign w_lane = mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = w_lane;
        unique case (r_func3)
            F3_B:    w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_BU:   w_load_ext = {24'h0, w_lane[7:0]};
            F3_HU:   w_load_ext = {16'h0, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    // Memory-side outputs are gated by state so they read 0 outside ACCESS (and on reset).
    assign w_in_access = (r_state == S_ACCESS);
    assign w_in_resp   = (r_state == S_RESP);

    assign req_ready = (r_state == S_IDLE);
    assign mem_req   = w_in_access;
    assign mem_we    = w_in_access & r_we;
    assign mem_addr  = w_in_access ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_be    = w_in_access ? w_be : 4'b0000;
    assign mem_wdata = w_in_access ? w_store_data : 32'h0;
    assign rsp_valid = w_in_resp;
    assign rsp_err   = w_in_resp & r_err;
    assign rsp_data  = w_in_resp ? r_rsp_data : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed-vector bench for lsu_ctrl (TIMEOUT=4): table of requests with hand-computed
// memory-side and response expectations, plus reset-mid-access and stray-ack sequences.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_delay;   // ack in mem cycle ack_delay+1; 99 = never
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_data;
        int          e_cycles;    // cycles with mem_req high
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  mem_cycles;
        int  lat;
        bit  done;
        @(negedge clk);
        check({v.name, ".ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_func3 = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func3 = 3'b000;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        mem_cycles = 0;
        lat        = 0;
        done       = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            if (c > 1) @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_DEAD;
            if (mem_req) begin
                mem_cycles++;
                check({v.name, ".mem_addr"}, mem_addr, v.e_addr);
                check({v.name, ".mem_be"}, {28'h0, mem_be}, {28'h0, v.e_be});
                if (mem_cycles == 1) begin
                    check({v.name, ".mem_we"}, mem_we, v.we);
                    check({v.name, ".mem_wdata"}, mem_wdata, v.e_wdata);
                end
                if (mem_cycles - 1 == v.ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (rsp_valid) begin
                done = 1'b1;
                lat  = c;
                check({v.name, ".rsp_err"}, rsp_err, v.e_err);
                check({v.name, ".rsp_data"}, rsp_data, v.e_data);
            end
        end
        mem_ack = 1'b0;
        check({v.name, ".rsp_seen"}, done, 1);
        check({v.name, ".mem_cycles"}, mem_cycles, v.e_cycles);
        check({v.name, ".latency"}, lat, v.e_cycles + 1);
        @(negedge clk);
        check({v.name, ".rsp_one_cycle"}, rsp_valid, 0);
        check({v.name, ".back_idle"}, req_ready, 1);
    endtask

    initial begin
        //           name          we    f3      addr          wdata          rdata         dly e_addr        e_be     e_wdata        err   e_data         cyc
        vecs[0]  = '{"lb_1003",    1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 32'h0000_1000, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80, 1};
        vecs[1]  = '{"lhu_2002",   1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 3, 32'h0000_2000, 4'b1100, 32'h0,        1'b0, 32'h0000_BEEF, 4};
        vecs[2]  = '{"sh_12",      1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'h1111_2222, 0, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0,        1};
        vecs[3]  = '{"lw_mis6",    1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        0};
        vecs[4]  = '{"ld_f3_011",  1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        0};
        vecs[5]  = '{"lw_tmo",     1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'h1234_5678, 99, 32'h0000_0040, 4'b1111, 32'h0,       1'b1, 32'h0,        4};
        vecs[6]  = '{"lw_ack_last",1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 3, 32'h0000_0040, 4'b1111, 32'h0,        1'b0, 32'hCAFE_F00D, 4};
        vecs[7]  = '{"sb_21",      1'b1, 3'b000, 32'h0000_0021, 32'h1234_56A5, 32'h0,        1, 32'h0000_0020, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0,        2};
        vecs[8]  = '{"lh_mis1",    1'b0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        0};
        vecs[9]  = '{"st_f3_011",  1'b1, 3'b011, 32'h0000_0000, 32'h5555_5555, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        0};
        vecs[10] = '{"lb_pos_2",   1'b0, 3'b000, 32'h0000_0302, 32'h0,        32'h007F_0000, 0, 32'h0000_0300, 4'b0100, 32'h0,        1'b0, 32'h0000_007F, 1};
        vecs[11] = '{"lbu_3",      1'b0, 3'b100, 32'h0000_0003, 32'h0,        32'h80FF_1234, 2, 32'h0000_0000, 4'b1000, 32'h0,        1'b0, 32'h0000_0080, 3};
        vecs[12] = '{"lh_neg_2",   1'b0, 3'b001, 32'h0000_0402, 32'h0,        32'h8001_FFFF, 0, 32'h0000_0400, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001, 1};
        vecs[13] = '{"sw_8",       1'b1, 3'b010, 32'h0000_0008, 32'h1122_3344, 32'h0,        0, 32'h0000_0008, 4'b1111, 32'h1122_3344, 1'b0, 32'h0,        1};

        // Reset state, with a legal request presented that must not be captured.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'h0000_0080;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", req_ready, 1);
        check("rst.mem_req", mem_req, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_be", {28'h0, mem_be}, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rsp_data", rsp_data, 0);
        check("rst.rsp_err", rsp_err, 0);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("post_rst.mem_req", mem_req, 0);
        check("post_rst.rsp_valid", rsp_valid, 0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Reset asserted in the second ACCESS cycle, then a late ack pulse.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'h0000_0100;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort.access1", mem_req, 1);
        @(negedge clk);
        check("abort.access2", mem_req, 1);
        rst = 1'b1;
        #1;
        check("abort.async_drop", mem_req, 0);
        check("abort.no_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check("abort.late_ack_rsp", rsp_valid, 0);
            check("abort.late_ack_req", mem_req, 0);
        end
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
